// File: rtl/vcap_pkg.sv
// Shared types and helpers for the video capture writer: FSM states, request layout, RGB444 quantiser.
package vcap_pkg;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_CAPT  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam int LINE_W = 9;
  localparam int COL_W  = 9;
  localparam int PIX_W  = 12;
  localparam int REQ_W  = LINE_W + COL_W + PIX_W;

  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic [COL_W-1:0]  col;
    logic [PIX_W-1:0]  data;
  } wr_req_t;

  // Keeps the odd bits so the output stage's bit-doubling expansion reproduces them exactly.
  function automatic logic [3:0] quant4(input logic [7:0] c);
    return {c[7], c[5], c[3], c[1]};
  endfunction

  function automatic logic [PIX_W-1:0] quant_rgb(input logic [23:0] p);
    return {quant4(p[23:16]), quant4(p[15:8]), quant4(p[7:0])};
  endfunction

endpackage

// File: rtl/vcap_wr_fifo.sv
// Synchronous write-request FIFO with show-ahead head; push+pop in one cycle is always accepted,
// a push into a full FIFO without a pop is dropped and flagged on o_drop.
module vcap_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 30
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign o_empty = (count == '0);
  assign o_full  = (count == FULL_CNT);
  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);
  assign o_drop  = i_push & ~push_ok;
  assign o_head  = mem[rptr];

  // When full, wptr == rptr: the slot being popped is overwritten at the same edge.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_cap_writer.sv
// Crops/decimates an RGB888 DE/VSYNC stream and queues RGB444 (line, col, data) frame-buffer writes.
// Build option VCAP_PIXEL_AVG_EN: horizontal decimation averages the pixel pair instead of keeping the even one.
module video_cap_writer import vcap_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_vsync,
  input  logic              i_de,
  input  logic [7:0]        i_r,
  input  logic [7:0]        i_g,
  input  logic [7:0]        i_b,
  input  logic [11:0]       i_x_offset,
  input  logic [11:0]       i_y_offset,
  input  logic [11:0]       i_x_win_size,
  input  logic [11:0]       i_y_win_size,
  input  logic              i_x_div2,
  input  logic              i_y_div2,
  output logic              o_wr_req,
  input  logic              i_wr_ack,
  output logic [LINE_W-1:0] o_wr_line,
  output logic [COL_W-1:0]  o_wr_col,
  output logic [PIX_W-1:0]  o_wr_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_ovf,
  output logic [1:0]        o_dbg_state
);

  // Write port: o_wr_req is valid whenever the FIFO holds an entry; o_wr_* show the head entry;
  // the head is consumed on any cycle where o_wr_req & i_wr_ack; ack without req has no effect.

  state_t        state;
  state_t        state_nxt;
  logic          frame_start;
  logic          done_nxt;
  logic          vs_q1;
  logic          vs_q2;
  logic          vs_rise;
  logic          p0_de;
  logic          de_d;
  logic [23:0]   p0_pix;
  logic [11:0]   sx;
  logic [11:0]   sy;
  logic [11:0]   rx;
  logic [11:0]   ry;
  logic [11:0]   x_idx;
  logic [11:0]   y_idx;
  logic          in_win;
  logic          emit;
  logic [23:0]   hold_pix;
  logic [23:0]   emit_pix;
  logic          q_valid;
  wr_req_t       q_req;
  wr_req_t       head;
  logic          fifo_push;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_drop;

`ifdef VCAP_PIXEL_AVG_EN
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction
`endif

  assign vs_rise = vs_q1 & ~vs_q2;

  // Window test runs on the registered pixel, with sx/sy counting pixels already seen.
  assign rx     = sx - i_x_offset;
  assign ry     = sy - i_y_offset;
  assign x_idx  = i_x_div2 ? {1'b0, rx[11:1]} : rx;
  assign y_idx  = i_y_div2 ? {1'b0, ry[11:1]} : ry;
  assign in_win = p0_de && (sx >= i_x_offset) && (sy >= i_y_offset) &&
                  (x_idx < i_x_win_size) && (y_idx < i_y_win_size) &&
                  !(i_y_div2 && ry[0]);
  assign emit   = in_win & (~i_x_div2 | rx[0]);

  always_comb begin
    emit_pix = p0_pix;
    if (i_x_div2) begin
`ifdef VCAP_PIXEL_AVG_EN
      emit_pix = {avg8(hold_pix[23:16], p0_pix[23:16]),
                  avg8(hold_pix[15:8],  p0_pix[15:8]),
                  avg8(hold_pix[7:0],   p0_pix[7:0])};
`else
      emit_pix = hold_pix;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      S_WAIT: begin
        if (vs_rise && i_enable) begin
          state_nxt   = S_CAPT;
          frame_start = 1'b1;
        end
      end
      S_CAPT: begin
        if (vs_rise) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (fifo_empty) begin
          done_nxt = 1'b1;
          if (i_enable) begin
            state_nxt   = S_CAPT;
            frame_start = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_WAIT;
      vs_q1        <= 1'b0;
      vs_q2        <= 1'b0;
      p0_de        <= 1'b0;
      de_d         <= 1'b0;
      p0_pix       <= '0;
      sx           <= '0;
      sy           <= '0;
      hold_pix     <= '0;
      q_valid      <= 1'b0;
      q_req        <= '0;
      o_frame_done <= 1'b0;
      o_ovf        <= 1'b0;
    end else begin
      state  <= state_nxt;
      vs_q1  <= i_vsync;
      vs_q2  <= vs_q1;
      p0_de  <= i_de;
      p0_pix <= {i_r, i_g, i_b};
      de_d   <= p0_de;

      if (p0_de)     sx <= sx + 12'd1;
      else if (de_d) sx <= '0;

      if (frame_start)                           sy <= '0;
      else if (de_d && !p0_de && sy != 12'hFFF)  sy <= sy + 12'd1;

      if (in_win && i_x_div2 && !rx[0]) hold_pix <= p0_pix;

      q_valid    <= emit && (state == S_CAPT);
      q_req.line <= y_idx[LINE_W-1:0];
      q_req.col  <= x_idx[COL_W-1:0];
      q_req.data <= quant_rgb(emit_pix);

      o_frame_done <= done_nxt;
      if (frame_start)    o_ovf <= 1'b0;
      else if (fifo_drop) o_ovf <= 1'b1;
    end
  end

  // Anything still in the pipeline after the closing vsync is discarded here.
  assign fifo_push = q_valid && (state == S_CAPT);

  vcap_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REQ_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_data  (q_req),
    .i_pop   (i_wr_ack),
    .o_head  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_drop  (fifo_drop)
  );

  assign o_wr_req    = ~fifo_empty;
  assign o_wr_line   = fifo_empty ? '0 : head.line;
  assign o_wr_col    = fifo_empty ? '0 : head.col;
  assign o_wr_data   = fifo_empty ? '0 : head.data;
  assign o_busy      = (state != S_WAIT);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_video_cap_writer.sv
// Bench for video_cap_writer: table of crop/decimate frames plus hand-written overflow, flush and reset sequences.
module tb_video_cap_writer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        vsync;
  logic        de;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic [11:0] x_off;
  logic [11:0] y_off;
  logic [11:0] x_win;
  logic [11:0] y_win;
  logic        x_div2;
  logic        y_div2;
  logic        wr_req;
  logic        wr_ack;
  logic [8:0]  wr_line;
  logic [8:0]  wr_col;
  logic [11:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic        ovf;
  logic [1:0]  dbg_state;

  video_cap_writer #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_vsync      (vsync),
    .i_de         (de),
    .i_r          (r),
    .i_g          (g),
    .i_b          (b),
    .i_x_offset   (x_off),
    .i_y_offset   (y_off),
    .i_x_win_size (x_win),
    .i_y_win_size (y_win),
    .i_x_div2     (x_div2),
    .i_y_div2     (y_div2),
    .o_wr_req     (wr_req),
    .i_wr_ack     (wr_ack),
    .o_wr_line    (wr_line),
    .o_wr_col     (wr_col),
    .o_wr_data    (wr_data),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_ovf        (ovf),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          xoff;
    int          yoff;
    int          xw;
    int          yw;
    bit          xd;
    bit          yd;
    int          sw;
    int          sh;
    int          pat;
    int          exp_n;
    bit          chk_data;
    logic [11:0] exp_data;
  } vec_t;

`ifdef VCAP_PIXEL_AVG_EN
  localparam logic [11:0] T2_DATA = 12'h700;
`else
  localparam logic [11:0] T2_DATA = 12'h000;
`endif

  vec_t        vecs[6];
  logic [29:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          writes = 0;
  int          last_pop_cyc = 0;
  int          done_cyc = 0;
  bit          done_seen = 0;
  logic [11:0] last_data = '0;
  bit          model_en = 1;
  int          model_limit = -1;
  int          model_pushes = 0;
  logic [23:0] model_hold = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] q4(input logic [7:0] c);
    return {c[7], c[5], c[3], c[1]};
  endfunction

  function automatic logic [23:0] pair_pix(input logic [23:0] ev, input logic [23:0] od);
`ifdef VCAP_PIXEL_AVG_EN
    logic [23:0] res;
    for (int c = 0; c < 3; c++) begin
      int s;
      s = (int'(ev[c*8 +: 8]) + int'(od[c*8 +: 8]) + 1) / 2;
      res[c*8 +: 8] = 8'(s);
    end
    return res;
`else
    return (od == od) ? ev : ev;
`endif
  endfunction

  // scoreboard: sample at negedge, pop on every accepted write
  task automatic monitor();
    logic [29:0] got;
    logic [29:0] exp;
    if (rst_n && wr_req && wr_ack) begin
      got = {wr_line, wr_col, wr_data};
      writes++;
      last_pop_cyc = cyc;
      last_data = wr_data;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got=%0h exp=none", got);
      end else begin
        exp = exp_q.pop_front();
        check("wr_entry", 32'(got), 32'(exp));
      end
    end
    if (frame_done && !done_seen) begin
      done_seen = 1;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // reference model for one source pixel at source position (x, y)
  task automatic model_pixel(input int x, input int y, input logic [23:0] pix);
    int rx, ry, xi, yi;
    logic [23:0] o;
    if (!model_en) return;
    if (x < int'(x_off) || y < int'(y_off)) return;
    rx = x - int'(x_off);
    ry = y - int'(y_off);
    xi = x_div2 ? rx / 2 : rx;
    yi = y_div2 ? ry / 2 : ry;
    if (xi >= int'(x_win) || yi >= int'(y_win)) return;
    if (y_div2 && (ry % 2 == 1)) return;
    if (x_div2 && (rx % 2 == 0)) begin
      model_hold = pix;
      return;
    end
    o = x_div2 ? pair_pix(model_hold, pix) : pix;
    if (model_limit >= 0 && model_pushes >= model_limit) return;
    model_pushes++;
    exp_q.push_back({9'(yi), 9'(xi), q4(o[23:16]), q4(o[15:8]), q4(o[7:0])});
  endtask

  function automatic logic [23:0] gen_pix(input int pat, input int x);
    case (pat)
      1:       return 24'hAA55FF;
      2:       return {((x % 2) == 1) ? 8'hFE : 8'h00, 16'h0000};
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic drive_line(input int w, input int y, input int pat);
    logic [23:0] pix;
    for (int x = 0; x < w; x++) begin
      pix = gen_pix(pat, x);
      {r, g, b} = pix;
      de = 1'b1;
      model_pixel(x, y, pix);
      tick();
    end
    de = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_seen && n < 300) begin
      tick();
      n++;
    end
    check("frame_done", 32'(done_seen), 32'd1);
  endtask

  task automatic set_cfg(input vec_t v);
    x_off  = 12'(v.xoff);
    y_off  = 12'(v.yoff);
    x_win  = 12'(v.xw);
    y_win  = 12'(v.yw);
    x_div2 = v.xd;
    y_div2 = v.yd;
  endtask

  task automatic run_vec(input vec_t v);
    set_cfg(v);
    model_en = 1;
    model_pushes = 0;
    writes = 0;
    for (int y = 0; y < v.sh; y++) drive_line(v.sw, y, v.pat);
    repeat (3) tick();
    done_seen = 0;
    pulse_vsync();
    wait_done();
    check("frame_writes", 32'(writes), 32'(v.exp_n));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    if (v.chk_data) check("pixel_data", 32'(last_data), 32'(v.exp_data));
    repeat (2) tick();
    check("busy_after_frame", 32'(busy), 32'd1);
  endtask

  initial begin
    vec_t v;
    //          xoff yoff xw yw xd    yd    sw sh pat n  chk   data
    vecs[0] = '{0,   0,   4, 2, 1'b0, 1'b0, 4, 2, 1,  8, 1'b1, 12'hF0F};
    vecs[1] = '{0,   0,   2, 1, 1'b1, 1'b1, 4, 2, 2,  2, 1'b1, T2_DATA};
    vecs[2] = '{3,   1,   2, 1, 1'b0, 1'b0, 6, 3, 0,  2, 1'b0, 12'h000};
    vecs[3] = '{1,   2,   3, 2, 1'b1, 1'b0, 8, 5, 0,  6, 1'b0, 12'h000};
    vecs[4] = '{0,   0,   5, 2, 1'b0, 1'b1, 6, 5, 0, 10, 1'b0, 12'h000};
    vecs[5] = '{0,   0,   8, 8, 1'b0, 1'b0, 3, 2, 0,  6, 1'b0, 12'h000};

    rst_n = 1'b0; enable = 1'b0; vsync = 1'b0; de = 1'b0;
    r = '0; g = '0; b = '0; wr_ack = 1'b0;
    set_cfg(vecs[0]);
    repeat (3) tick();
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_wr_line", 32'(wr_line), 32'd0);
    check("rst_wr_col", 32'(wr_col), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    wr_ack = 1'b1;
    pulse_vsync();
    tick();
    check("busy_after_start", 32'(busy), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // overflow: ack held low, six in-window pixels into a four-entry FIFO
    v = vecs[0];
    v.xw = 6; v.yw = 1;
    set_cfg(v);
    wr_ack = 1'b0;
    model_en = 1; model_pushes = 0; model_limit = DEPTH; writes = 0;
    drive_line(6, 0, 0);
    repeat (3) tick();
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_req_held", 32'(wr_req), 32'd1);
    wr_ack = 1'b1;
    repeat (8) tick();
    check("ovf_writes", 32'(writes), 32'(DEPTH));
    check("ovf_sticky", 32'(ovf), 32'd1);
    done_seen = 0;
    pulse_vsync();
    wait_done();
    tick();
    check("ovf_cleared", 32'(ovf), 32'd0);
    model_limit = -1;

    // flush: vsync with three queued, a new line arriving, ack every second cycle
    v.xw = 8; v.yw = 2;
    set_cfg(v);
    wr_ack = 1'b0;
    model_pushes = 0; writes = 0;
    drive_line(3, 0, 0);
    repeat (3) tick();
    check("flush_queued", 32'(wr_req), 32'd1);
    model_en = 0;
    done_seen = 0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      wr_ack = 1'(i % 2);
      vsync = (i < 2);
      de = (i < 3);
      {r, g, b} = 24'($urandom);
      tick();
    end
    vsync = 1'b0; de = 1'b0; wr_ack = 1'b1; model_en = 1;
    check("flush_done", 32'(done_seen), 32'd1);
    check("flush_writes", 32'(writes), 32'd3);
    check("flush_done_timing", 32'(done_cyc - last_pop_cyc), 32'd2);
    tick();
    check("flush_recapt", 32'(dbg_state), 32'd1);

    // asynchronous reset in the middle of a line with entries queued
    wr_ack = 1'b0;
    for (int x = 0; x < 5; x++) begin
      {r, g, b} = 24'($urandom);
      de = 1'b1;
      model_pixel(x, 0, {r, g, b});
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_req", 32'(wr_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    de = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wr_ack = 1'b1;
    tick();
    check("post_rst_state", 32'(dbg_state), 32'd0);
    pulse_vsync();
    tick();
    check("post_rst_busy", 32'(busy), 32'd1);
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
